nsw_bbm_seq: RTL

// - Break-before-make sequencer producing the SW controls for a bank of nsw1 analog switches.
// - Accepts a new switch-select pattern over a valid/ready handshake.
// - Opens switches leaving the pattern, waits a programmable dead time, then closes newly selected switches.
// - Holds SETTLE cycles, then reports DONE. Sits in the digital control domain feeding the analog switch matrix.

---
 rtl/nsw_bbm_pkg.sv | 24 ++
 rtl/nsw_dly_cnt.sv | 32 +++
 rtl/nsw_bbm_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nsw_bbm_pkg.sv
// rtl/nsw_bbm_pkg.sv - shared types, defaults and helpers for the nsw1 break-before-make sequencer
package nsw_bbm_pkg;

    localparam int N_SW_DEF  = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_DEAD,
        ST_MAKE,
        ST_SETTLE
    } state_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/nsw_dly_cnt.sv
// rtl/nsw_dly_cnt.sv - loadable saturating down counter with zero / at-most-one flags
module nsw_dly_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_le1
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_le1  = (r_cnt <= C_ONE);

endmodule

// File: rtl/nsw_bbm_seq.sv
// rtl/nsw_bbm_seq.sv - break-before-make sequencer driving the SW pins of an nsw1 switch bank
module nsw_bbm_seq
    import nsw_bbm_pkg::*;
#(
    parameter int N_SW       = N_SW_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int ONEHOT_CHK = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    input  logic [N_SW-1:0]  i_req_sel,
    output logic             o_req_ready,
    input  logic [CNT_W-1:0] i_dead_cyc,
    input  logic [CNT_W-1:0] i_settle_cyc,
    input  logic             i_abort,
    output logic [N_SW-1:0]  o_sw,
    output logic             o_done,
    output logic             o_err
);

    state_t            r_state;
    logic [N_SW-1:0]   r_sw;
    logic [N_SW-1:0]   r_tgt;
    logic [CNT_W-1:0]  r_dc;
    logic [CNT_W-1:0]  r_sc;
    logic              r_abrt;
    logic              r_ready;
    logic              r_done;
    logic              r_err;

    state_t            w_nxt_state;
    logic [N_SW-1:0]   w_sw_nxt;
    logic [N_SW-1:0]   w_tgt_nxt;
    logic [CNT_W-1:0]  w_dc_nxt;
    logic [CNT_W-1:0]  w_sc_nxt;
    logic              w_abrt_nxt;
    logic              w_ready_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_cnt_le1;
    logic              w_accept;
    logic              w_multi;

    assign w_accept = i_req_valid && r_ready;
    assign w_multi  = (ONEHOT_CHK != 0) && (popcount(32'(i_req_sel)) > 1);

    nsw_dly_cnt #(
        .CNT_W (CNT_W)
    ) u_dly_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_cnt_load),
        .i_val   (w_cnt_val),
        .i_dec   (w_cnt_dec),
        .o_zero  (w_cnt_zero),
        .o_le1   (w_cnt_le1)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_sw    <= '0;
            r_tgt   <= '0;
            r_dc    <= '0;
            r_sc    <= '0;
            r_abrt  <= 1'b0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_sw    <= w_sw_nxt;
            r_tgt   <= w_tgt_nxt;
            r_dc    <= w_dc_nxt;
            r_sc    <= w_sc_nxt;
            r_abrt  <= w_abrt_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_sw_nxt    = r_sw;
        w_tgt_nxt   = r_tgt;
        w_dc_nxt    = r_dc;
        w_sc_nxt    = r_sc;
        w_abrt_nxt  = r_abrt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_val   = r_dc;
        w_cnt_dec   = 1'b0;

        // Abort opens everything and reuses DEAD as the discharge wait; r_abrt sends DEAD straight home.
        if (i_abort) begin
            w_sw_nxt    = '0;
            w_tgt_nxt   = '0;
            w_abrt_nxt  = 1'b1;
            w_cnt_load  = 1'b1;
            w_cnt_val   = i_dead_cyc;
            w_nxt_state = ST_DEAD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_multi) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_tgt_nxt = i_req_sel;
                            w_dc_nxt  = i_dead_cyc;
                            w_sc_nxt  = i_settle_cyc;
                            if (i_req_sel == r_sw) begin
                                w_cnt_load  = 1'b1;
                                w_cnt_val   = i_settle_cyc;
                                w_nxt_state = ST_SETTLE;
                            end else begin
                                w_nxt_state = ST_BREAK;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    w_sw_nxt    = r_sw & r_tgt;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = r_dc;
                    w_nxt_state = ST_DEAD;
                end
                ST_DEAD: begin
                    // Exit at count<=1 so DEAD lasts dc cycles, and still one cycle for dc=0.
                    if (w_cnt_le1) begin
                        if (r_abrt) begin
                            w_abrt_nxt  = 1'b0;
                            w_nxt_state = ST_IDLE;
                        end else begin
                            w_nxt_state = ST_MAKE;
                        end
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                ST_MAKE: begin
                    w_sw_nxt    = r_tgt;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = r_sc;
                    w_nxt_state = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_cnt_zero) begin
                        w_done_nxt  = 1'b1;
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end

        w_ready_nxt = (w_nxt_state == ST_IDLE);
    end

    assign o_sw        = r_sw;
    assign o_req_ready = r_ready;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
